// File: rtl/sort_9_if.sv
// rtl/sort_9_if.sv - start/node/result bundle for the 9-entry Huffman node sorter
interface sort_9_if #(
  parameter int DATA_W = 13
);
  logic              sort_begin;
  logic [DATA_W-1:0] node0, node1, node2, node3, node4, node5, node6, node7, node8;
  logic [DATA_W-1:0] new1, new2, new3, new4, new5, new6, new7, new8, new9;
  logic              sort_over;

  // Requester side: issues the start and the unsorted nodes.
  modport master (
    output sort_begin,
    output node0, node1, node2, node3, node4, node5, node6, node7, node8,
    input  new1, new2, new3, new4, new5, new6, new7, new8, new9,
    input  sort_over
  );

  // Sorter side.
  modport slave (
    input  sort_begin,
    input  node0, node1, node2, node3, node4, node5, node6, node7, node8,
    output new1, new2, new3, new4, new5, new6, new7, new8, new9,
    output sort_over
  );
endinterface

// File: rtl/sort_9.sv
// rtl/sort_9.sv - odd-even transposition sorter, 9 nodes, one phase per clock (option: SORT9_FULLKEY_EN)
module sort_9 #(
  parameter int DATA_W  = 13,
  parameter int KEY_LSB = 5
) (
  input  logic   CLK,
  input  logic   nRST,
  sort_9_if.slave sif
);

  typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

  state_t            state_q, state_d;
  logic [3:0]        phase_q, phase_d;
  logic              over_q, over_d;
  logic [DATA_W-1:0] w_q   [9];
  logic [DATA_W-1:0] w_d   [9];
  logic [DATA_W-1:0] new_q [9];
  logic [DATA_W-1:0] new_d [9];
  logic [DATA_W-1:0] node_in [9];
  logic [DATA_W-1:0] ex    [9];

  // Ordering predicate for one compare-exchange: true means a must move after b.
  // Key-only compare keeps equal keys in place, which makes the sort stable.
  function automatic logic gt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
`ifdef SORT9_FULLKEY_EN
    return {a[DATA_W-1:KEY_LSB], a[KEY_LSB-1:0]} > {b[DATA_W-1:KEY_LSB], b[KEY_LSB-1:0]};
`else
    return a[DATA_W-1:KEY_LSB] > b[DATA_W-1:KEY_LSB];
`endif
  endfunction

  assign node_in[0] = sif.node0;
  assign node_in[1] = sif.node1;
  assign node_in[2] = sif.node2;
  assign node_in[3] = sif.node3;
  assign node_in[4] = sif.node4;
  assign node_in[5] = sif.node5;
  assign node_in[6] = sif.node6;
  assign node_in[7] = sif.node7;
  assign node_in[8] = sif.node8;

  // One network phase: even phases pair (0,1)..(6,7), odd phases pair (1,2)..(7,8).
  always_comb begin
    for (int i = 0; i < 9; i++) ex[i] = w_q[i];
    for (int i = 0; i < 8; i++) begin
      if ((i[0] == phase_q[0]) && gt(w_q[i], w_q[i+1])) begin
        ex[i]   = w_q[i+1];
        ex[i+1] = w_q[i];
      end
    end
  end

  // Next-state: accept a start from IDLE/DONE, run nine phases, publish on the last one.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    over_d  = over_q;
    for (int i = 0; i < 9; i++) begin
      w_d[i]   = w_q[i];
      new_d[i] = new_q[i];
    end
    case (state_q)
      IDLE, DONE: begin
        if (sif.sort_begin) begin
          for (int i = 0; i < 9; i++) w_d[i] = node_in[i];
          phase_d = 4'd0;
          over_d  = 1'b0;
          state_d = SORT;
        end
      end
      SORT: begin
        for (int i = 0; i < 9; i++) w_d[i] = ex[i];
        phase_d = phase_q + 4'd1;
        if (phase_q == 4'd8) begin
          for (int i = 0; i < 9; i++) new_d[i] = ex[i];
          over_d  = 1'b1;
          phase_d = 4'd0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything so no partial result leaks out.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      phase_q <= 4'd0;
      over_q  <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        w_q[i]   <= '0;
        new_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      over_q  <= over_d;
      for (int i = 0; i < 9; i++) begin
        w_q[i]   <= w_d[i];
        new_q[i] <= new_d[i];
      end
    end
  end

  assign sif.new1      = new_q[0];
  assign sif.new2      = new_q[1];
  assign sif.new3      = new_q[2];
  assign sif.new4      = new_q[3];
  assign sif.new5      = new_q[4];
  assign sif.new6      = new_q[5];
  assign sif.new7      = new_q[6];
  assign sif.new8      = new_q[7];
  assign sif.new9      = new_q[8];
  assign sif.sort_over = over_q;

endmodule

// File: tb/tb_sort_9.sv
// tb/tb_sort_9.sv - self-checking bench for sort_9 against a queue-level model
module tb_sort_9;

  typedef logic [12:0] node_t;
  typedef node_t nodes_t [9];

  logic   CLK = 1'b0;
  logic   nRST;
  nodes_t stim;
  node_t  got [9];
  int     checks = 0;
  int     errors = 0;

  nodes_t m_new  = '{default: '0};
  nodes_t m_pend = '{default: '0};
  logic   m_over = 1'b0;
  bit     m_busy = 1'b0;
  int     m_cnt  = 0;

  sort_9_if #(.DATA_W(13)) bus ();

  sort_9 #(.DATA_W(13), .KEY_LSB(5)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .sif  (bus)
  );

  always #5 CLK = ~CLK;

  assign bus.node0 = stim[0];
  assign bus.node1 = stim[1];
  assign bus.node2 = stim[2];
  assign bus.node3 = stim[3];
  assign bus.node4 = stim[4];
  assign bus.node5 = stim[5];
  assign bus.node6 = stim[6];
  assign bus.node7 = stim[7];
  assign bus.node8 = stim[8];
  assign got[0] = bus.new1;
  assign got[1] = bus.new2;
  assign got[2] = bus.new3;
  assign got[3] = bus.new4;
  assign got[4] = bus.new5;
  assign got[5] = bus.new6;
  assign got[6] = bus.new7;
  assign got[7] = bus.new8;
  assign got[8] = bus.new9;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit after(input node_t a, input node_t b);
`ifdef SORT9_FULLKEY_EN
    return a > b;
`else
    return a[12:5] > b[12:5];
`endif
  endfunction

  // Reference ordering: stable insertion sort.
  task automatic ref_sort(input nodes_t in, output nodes_t out);
    node_t q [$];
    int    pos;
    for (int j = 0; j < 9; j++) begin
      pos = q.size();
      while (pos > 0 && after(q[pos-1], in[j])) pos--;
      q.insert(pos, in[j]);
    end
    for (int j = 0; j < 9; j++) out[j] = q[j];
  endtask

  // Transaction model: start accepted when idle, result appears nine edges later.
  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_new  = '{default: '0};
      m_over = 1'b0;
      m_busy = 1'b0;
      m_cnt  = 0;
    end else if (m_busy) begin
      m_cnt++;
      if (m_cnt == 9) begin
        m_new  = m_pend;
        m_over = 1'b1;
        m_busy = 1'b0;
      end
    end else if (bus.sort_begin) begin
      ref_sort(stim, m_pend);
      m_busy = 1'b1;
      m_cnt  = 0;
      m_over = 1'b0;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge CLK) begin
    for (int j = 0; j < 9; j++) chk($sformatf("new%0d", j + 1), 32'(got[j]), 32'(m_new[j]));
    chk("sort_over", 32'(bus.sort_over), 32'(m_over));
  end

  task automatic wait_done(input int poke, input nodes_t alt, output int k);
    k = 0;
    while (!bus.sort_over && k < 20) begin
      @(posedge CLK);
      k++;
      @(negedge CLK);
      if (k == poke) begin
        bus.sort_begin = 1'b1;
        stim = alt;
      end else begin
        bus.sort_begin = 1'b0;
      end
    end
  endtask

  task automatic start(input nodes_t n);
    @(negedge CLK);
    stim = n;
    bus.sort_begin = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    bus.sort_begin = 1'b0;
  endtask

  initial begin
    nodes_t rev, srt, tie, other;
    int     lat;
    int     pulses;
    node_t  keep;

    for (int i = 0; i < 9; i++) begin
      rev[i]   = node_t'(((9 - i) << 5) | i);
      srt[i]   = node_t'((i << 5) | i);
      tie[i]   = node_t'((10 << 5) | i);
      other[i] = node_t'(13'h1A5 + i * 13'h2B3);
    end
    srt[8] = 13'h1FFF;
    tie[0] = 13'h0A3;
    tie[1] = 13'h0A1;

    nRST = 1'b0;
    bus.sort_begin = 1'b0;
    stim = '{default: '0};

    // Reset holds everything at zero, start ignored.
    repeat (2) @(negedge CLK);
    bus.sort_begin = 1'b1;
    stim = rev;
    repeat (3) @(negedge CLK);
    bus.sort_begin = 1'b0;
    chk("rst_new1", 32'(bus.new1), 32'h0);
    chk("rst_new9", 32'(bus.new9), 32'h0);
    chk("rst_over", 32'(bus.sort_over), 32'h0);
    nRST = 1'b1;
    repeat (2) @(negedge CLK);

    // Reverse order.
    start(rev);
    wait_done(-1, other, lat);
    chk("rev_latency", 32'(lat), 32'd9);
    chk("rev_new1", 32'(bus.new1), 32'h028);
    chk("rev_new2", 32'(bus.new2), 32'h047);
    chk("rev_new3", 32'(bus.new3), 32'h066);
    chk("rev_new4", 32'(bus.new4), 32'h085);
    chk("rev_new5", 32'(bus.new5), 32'h0A4);
    chk("rev_new6", 32'(bus.new6), 32'h0C3);
    chk("rev_new7", 32'(bus.new7), 32'h0E2);
    chk("rev_new8", 32'(bus.new8), 32'h101);
    chk("rev_new9", 32'(bus.new9), 32'h120);

    // Already sorted with extremes.
    start(srt);
    chk("restart_over_drop", 32'(bus.sort_over), 32'h0);
    chk("restart_old_held", 32'(bus.new1), 32'h028);
    wait_done(-1, other, lat);
    chk("srt_latency", 32'(lat), 32'd9);
    chk("srt_new1", 32'(bus.new1), 32'h000);
    chk("srt_new8", 32'(bus.new8), 32'h0E7);
    chk("srt_new9", 32'(bus.new9), 32'h1FFF);

    // Ties.
    start(tie);
    wait_done(-1, other, lat);
`ifdef SORT9_FULLKEY_EN
    chk("tie_new1", 32'(bus.new1), 32'h0A1);
    chk("tie_new2", 32'(bus.new2), 32'h0A3);
`else
    chk("tie_new1", 32'(bus.new1), 32'h0A3);
    chk("tie_new2", 32'(bus.new2), 32'h0A1);
`endif
    keep = bus.new1;

    // Hold in DONE while inputs wander.
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      stim[c] = node_t'(13'h1F00 - c);
    end
    chk("hold_over", 32'(bus.sort_over), 32'h1);
    chk("hold_new1", 32'(bus.new1), 32'(keep));

    // Start ignored mid-sort (sampled at edge 4).
    start(rev);
    wait_done(3, other, lat);
    chk("ignore_latency", 32'(lat), 32'd9);
    chk("ignore_new1", 32'(bus.new1), 32'h028);

    // Back-to-back sorts with sort_begin held high.
    pulses = 0;
    @(negedge CLK);
    bus.sort_begin = 1'b1;
    stim = other;
    for (int c = 0; c < 25; c++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (bus.sort_over) pulses++;
      for (int j = 0; j < 9; j++) stim[j] = node_t'((c * 37 + j * 1013 + 5) & 13'h1FFF);
    end
    bus.sort_begin = 1'b0;
    chk("b2b_pulses", 32'(pulses), 32'd2);
    wait_done(-1, other, lat);
    chk("b2b_tail", 32'(bus.sort_over), 32'h1);

    // Reset mid-sort, then a clean sort.
    start(other);
    repeat (4) @(posedge CLK);
    #2 nRST = 1'b0;
    #1;
    chk("midrst_new1", 32'(bus.new1), 32'h0);
    chk("midrst_new9", 32'(bus.new9), 32'h0);
    chk("midrst_over", 32'(bus.sort_over), 32'h0);
    @(negedge CLK);
    nRST = 1'b1;
    start(rev);
    wait_done(-1, other, lat);
    chk("post_rst_latency", 32'(lat), 32'd9);
    chk("post_rst_new9", 32'(bus.new9), 32'h120);

    repeat (2) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
